// File: rtl/alu_pkg.sv
// Shared ALU op codes (also used by the ALU decoder) and execution-unit FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MUL  = 4'h2,
    ALU_DIV  = 4'h3,
    ALU_SLL  = 4'h4,
    ALU_SRL  = 4'h5,
    ALU_AND  = 4'h6,
    ALU_OR   = 4'h7,
    ALU_XOR  = 4'h8,
    ALU_NOR  = 4'h9,
    ALU_JR   = 4'hA,
    ALU_NAND = 4'hB,
    ALU_NOT  = 4'hC,
    ALU_SLT  = 4'hD,
    ALU_SGT  = 4'hE,
    ALU_ILL  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider; one bit per cycle
// over WIDTH cycles, both sharing a single WIDTH+1 bit adder.
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy;
  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;   // product high half / partial remainder
  logic [WIDTH-1:0] sh;    // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;

  // Division subtracts via ~b + 1; sum[WIDTH] set means the trial went negative.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (div_q) begin
      add_x   = {acc, sh[WIDTH-1]};
      add_y   = ~{1'b0, opnd};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, acc};
      add_y   = sh[0] ? {1'b0, opnd} : '0;
    end
    sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
  end

  always_comb begin
    lo = '0;
    hi = '0;
    if (div_q) begin
      lo = {sh[WIDTH-2:0], ~sum[WIDTH]};
      hi = sum[WIDTH] ? add_x[WIDTH-1:0] : sum[WIDTH-1:0];
    end else begin
      lo = {sum[0], sh[WIDTH-1:1]};
      hi = sum[WIDTH:1];
    end
  end

  assign done = busy && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sh    <= '0;
      opnd  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      div_q <= is_div;
      cnt   <= '0;
      acc   <= '0;
      sh    <= a;
      opnd  <= b;
    end else if (busy) begin
      acc <= hi;
      sh  <= lo;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage execution unit: single-cycle ops finish next cycle, mult/div iterate WIDTH cycles.
// Handshake: a request transfers on a rising edge with in_valid & in_ready; a result transfers with out_valid & out_ready, and results hold steady until then.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             err,
  output alu_state_e       dbg_state
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state;
  alu_state_e       next_state;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic             div0_q;
  logic [WIDTH-1:0] sc_res;
  logic             sc_err;

  assign accept    = in_valid && in_ready;
  assign md_start  = accept && (alucontrol == ALU_MUL || alucontrol == ALU_DIV);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  mul_div_iter #(.WIDTH(WIDTH)) u_mul_div (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .is_div  (alucontrol == ALU_DIV),
    .a       (a),
    .b       (b),
    .done    (md_done),
    .lo      (md_lo),
    .hi      (md_hi)
  );

  // Anything not decoded (including 1111 and unknown codes) reports err with a zero result.
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (alucontrol)
      ALU_ADD:  sc_res = a + b;
      ALU_SUB:  sc_res = a - b;
      ALU_MUL,
      ALU_DIV:  sc_res = '0;
      ALU_SLL:  sc_res = a << b[SHW-1:0];
      ALU_SRL:  sc_res = a >> b[SHW-1:0];
      ALU_AND:  sc_res = a & b;
      ALU_OR:   sc_res = a | b;
      ALU_XOR:  sc_res = a ^ b;
      ALU_NOR:  sc_res = ~(a | b);
      ALU_JR:   sc_res = a;
      ALU_NAND: sc_res = ~(a & b);
      ALU_NOT:  sc_res = ~a;
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SGT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      default: begin
        sc_res = '0;
        sc_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (alucontrol)
            ALU_MUL: next_state = MUL;
            ALU_DIV: next_state = DIV;
            default: next_state = DONE;
          endcase
        end
      end
      MUL, DIV: if (md_done) next_state = DONE;
      DONE:     if (out_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Divide-by-zero needs no special datapath: the restoring divider naturally
  // yields all-ones quotient and remainder = a; only err must be flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
      div0_q    <= 1'b0;
    end else if (accept) begin
      div0_q <= (b == '0);
      if (next_state == DONE) begin
        result    <= sc_res;
        result_hi <= '0;
        zero      <= (sc_res == '0);
        err       <= sc_err;
      end
    end else if (md_done) begin
      result    <= md_lo;
      result_hi <= md_hi;
      zero      <= (md_lo == '0);
      err       <= (state == DIV) && div0_q;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomized checks of alu_multicycle (WIDTH=32) against an arithmetic reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alucontrol = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         err;
  alu_state_e   dbg_state;

  int checks = 0;
  int failures = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .zero       (zero),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the op table evaluated with wide plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic [W-1:0] h, output logic e);
    logic [63:0] p;
    r = '0; h = '0; e = 1'b0;
    case (op)
      4'h0: r = x + y;
      4'h1: r = x - y;
      4'h2: begin p = {32'h0, x} * {32'h0, y}; r = p[31:0]; h = p[63:32]; end
      4'h3: begin
        if (y == 0) begin r = 32'hFFFF_FFFF; h = x; e = 1'b1; end
        else begin r = x / y; h = x % y; end
      end
      4'h4: r = x << (y % 32);
      4'h5: r = x >> (y % 32);
      4'h6: r = x & y;
      4'h7: r = x | y;
      4'h8: r = x ^ y;
      4'h9: r = ~(x | y);
      4'hA: r = x;
      4'hB: r = ~(x & y);
      4'hC: r = ~x;
      4'hD: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'hE: r = ($signed(x) > $signed(y)) ? 32'd1 : 32'd0;
      default: begin r = '0; e = 1'b1; end
    endcase
  endtask

  // Issue one op, measure latency, hold out_ready low for 'hold' cycles, then accept.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    logic [W-1:0] er, eh;
    logic ee;
    int lat, el;
    model(op, x, y, er, eh, ee);
    el = (op == 4'h2 || op == 4'h3) ? 1 + W : 1;
    @(negedge clk);
    check($sformatf("in_ready_idle op%0h", op), in_ready, 1);
    in_valid = 1'b1; alucontrol = op; a = x; b = y;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0h", op), lat, el);
    for (int h = 0; h <= hold; h++) begin
      check($sformatf("out_valid op%0h h%0d", op, h), out_valid, 1);
      check($sformatf("in_ready_busy op%0h h%0d", op, h), in_ready, 0);
      check($sformatf("result op%0h a=%0h b=%0h", op, x, y), result, er);
      check($sformatf("result_hi op%0h a=%0h b=%0h", op, x, y), result_hi, eh);
      check($sformatf("zero op%0h", op), zero, (er == 0));
      check($sformatf("err op%0h", op), err, ee);
      if (h < hold) begin
        in_valid = 1'b1; alucontrol = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
        @(negedge clk);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("released op%0h", op), out_valid, 0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset result", result, 0);
    check("reset result_hi", result_hi, 0);
    check("reset zero", zero, 0);
    check("reset err", err, 0);
    check("reset state", dbg_state, IDLE);
    reset_n = 1'b1;

    do_op(4'h0, 32'hFFFF_FFFF, 32'h1, 0);
    do_op(4'h1, 32'd3, 32'd5, 0);
    do_op(4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(4'h3, 32'd100, 32'd7, 0);
    do_op(4'h3, 32'd5, 32'd0, 0);
    do_op(4'hD, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'hE, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(4'h4, 32'd1, 32'h21, 0);
    do_op(4'hF, 32'h1234, 32'h5678, 0);
    do_op(4'h2, 32'd0, 32'h55, 0);
    do_op(4'h0, 32'd7, 32'd9, 5);
    do_op(4'h3, 32'hDEAD_BEEF, 32'h123, 5);

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; alucontrol = 4'h2; a = 32'hABCD; b = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midmul_reset out_valid", out_valid, 0);
    check("midmul_reset in_ready", in_ready, 1);
    check("midmul_reset result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(4'h0, 32'd2, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb % 64;
      do_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
